// File: rtl/mr_pkg.sv
// Shared types and defaults for the mr core fetch path.
// The fetch entry struct is sized by the package widths; mr_if defaults to them.
package mr_pkg;

  localparam int unsigned MR_XLEN    = 32;
  localparam int unsigned MR_IMAXLEN = 32;

  localparam logic [MR_XLEN-1:0] MR_RESET_PC = 32'h0000_0000;

  typedef struct packed {
    logic [MR_IMAXLEN-1:0] inst;
    logic [MR_XLEN-1:0]    pc;
  } mr_fetch_entry_t;

endpackage

// File: rtl/mr_fifo.sv
// Small synchronous FIFO with flush; head is visible combinationally.
// Depth must be a power of two so the pointers wrap for free.
module mr_fifo #(
  parameter int unsigned Width = 32,
  parameter int unsigned Depth = 2,
  localparam int unsigned PtrW = $clog2(Depth),
  localparam int unsigned CntW = $clog2(Depth) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             push,
  input  logic [Width-1:0] wdata,
  input  logic             pop,
  output logic [Width-1:0] rdata,
  output logic [CntW-1:0]  count,
  output logic             empty,
  output logic             full
);

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  rd_q, wr_q;
  logic [CntW-1:0]  count_q;
  logic             do_push, do_pop;

  assign empty   = (count_q == '0);
  assign full    = (count_q == CntW'(Depth));
  assign do_pop  = pop & ~empty;
  // A push into a full FIFO is only honoured when a pop frees the slot in the same cycle.
  assign do_push = push & (~full | do_pop);

  assign rdata = mem_q[rd_q];
  assign count = count_q;

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      rd_q    <= '0;
      wr_q    <= '0;
      count_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + PtrW'(1);
      if (do_pop)  rd_q <= rd_q + PtrW'(1);
      count_q <= count_q + CntW'(do_push) - CntW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && !flush && do_push) mem_q[wr_q] <= wdata;
  end

endmodule

// File: rtl/mr_if.sv
// Fetch stage of the mr core: credit-limited in-order fetch with redirect and stale-drop.
// Optional MR_IF_RSP_BYPASS_EN forwards a response straight to decode when the buffer is empty.
module mr_if
  import mr_pkg::*;
#(
  parameter int unsigned       XLEN     = MR_XLEN,
  parameter int unsigned       IMAXLEN  = MR_IMAXLEN,
  parameter logic [XLEN-1:0]   RESET_PC = MR_RESET_PC,
  parameter int unsigned       DEPTH    = 2
) (
  input  logic               clk,
  input  logic               rst,
  output logic               mem_req_valid,
  input  logic               mem_req_ready,
  output logic [XLEN-1:0]    mem_req_addr,
  input  logic               mem_rsp_valid,
  input  logic [IMAXLEN-1:0] mem_rsp_data,
  input  logic               redirect_valid,
  input  logic [XLEN-1:0]    redirect_pc,
  output logic [IMAXLEN-1:0] inst,
  output logic [XLEN-1:0]    inst_pc,
  output logic               inst_valid,
  input  logic               inst_ready
);

  localparam int unsigned CntW = $clog2(DEPTH) + 1;
  localparam int unsigned EntW = $bits(mr_fetch_entry_t);

  // Word-granular PC; the low two address bits are always zero.
  logic [XLEN-3:0] pc_q;
  logic [CntW-1:0] drop_q;

  logic [XLEN-3:0] tag_head;
  logic [CntW-1:0] tag_count, buf_count;
  logic            tag_empty, tag_full, buf_empty, buf_full;
  mr_fetch_entry_t buf_head, rsp_entry, out_entry;

  logic            credit, req_fire, rsp, rsp_keep, byp, buf_push, buf_pop;
  logic [CntW:0]   in_flight;
  logic [CntW-1:0] outstanding_next;

  assign in_flight = {1'b0, tag_count} + {1'b0, buf_count};
  assign credit    = (in_flight < (CntW + 1)'(DEPTH));

  assign mem_req_valid = ~rst & credit;
  assign mem_req_addr  = rst ? '0 : {pc_q, 2'b00};
  assign req_fire      = mem_req_valid & mem_req_ready;

  // Memory shares our reset, so anything arriving during rst is ignored.
  assign rsp      = mem_rsp_valid & ~rst & ~tag_empty;
  assign rsp_keep = rsp & (drop_q == '0) & ~redirect_valid;

  assign rsp_entry = '{inst: mem_rsp_data, pc: {tag_head, 2'b00}};

`ifdef MR_IF_RSP_BYPASS_EN
  assign byp       = rsp_keep & buf_empty;
  assign out_entry = byp ? rsp_entry : buf_head;
`else
  assign byp       = 1'b0;
  assign out_entry = buf_head;
`endif

  assign inst_valid = ~rst & (~buf_empty | byp);
  assign inst       = inst_valid ? out_entry.inst : '0;
  assign inst_pc    = inst_valid ? out_entry.pc : '0;

  assign buf_push = rsp_keep & ~(byp & inst_ready);
  assign buf_pop  = ~rst & ~buf_empty & inst_ready;

  // Stale requests still in flight once this cycle's accept/return events settle.
  assign outstanding_next = tag_count + CntW'(req_fire) - CntW'(rsp);

  mr_fifo #(
    .Width (XLEN - 2),
    .Depth (DEPTH)
  ) u_tag_q (
    .clk   (clk),
    .rst   (rst),
    .flush (1'b0),
    .push  (req_fire),
    .wdata (pc_q),
    .pop   (rsp),
    .rdata (tag_head),
    .count (tag_count),
    .empty (tag_empty),
    .full  (tag_full)
  );

  mr_fifo #(
    .Width (EntW),
    .Depth (DEPTH)
  ) u_inst_buf (
    .clk   (clk),
    .rst   (rst),
    .flush (redirect_valid),
    .push  (buf_push),
    .wdata (rsp_entry),
    .pop   (buf_pop),
    .rdata (buf_head),
    .count (buf_count),
    .empty (buf_empty),
    .full  (buf_full)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q   <= RESET_PC[XLEN-1:2];
      drop_q <= '0;
    end else if (redirect_valid) begin
      pc_q   <= redirect_pc[XLEN-1:2];
      drop_q <= outstanding_next;
    end else begin
      if (req_fire) pc_q <= pc_q + (XLEN - 2)'(1);
      if (rsp && drop_q != '0) drop_q <= drop_q - CntW'(1);
    end
  end

  logic unused_bits;
  assign unused_bits = ^{redirect_pc[1:0], tag_full, buf_full};

endmodule

// File: tb/tb_mr_if.sv
// Randomized bench for mr_if against a request/epoch model of fetch behaviour.
// Expected delivery stream: target, target+4, ... per epoch; stale epochs are dropped.
module tb_mr_if;

  localparam int unsigned DEPTH    = 2;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] DATA_KEY = 32'hA5A5_0000;

  logic        clk, rst;
  logic        mem_req_valid, mem_req_ready;
  logic [31:0] mem_req_addr;
  logic        mem_rsp_valid;
  logic [31:0] mem_rsp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic [31:0] inst, inst_pc;
  logic        inst_valid, inst_ready;

  mr_if #(
    .XLEN     (32),
    .IMAXLEN  (32),
    .RESET_PC (RESET_PC),
    .DEPTH    (DEPTH)
  ) u_dut (
    .clk            (clk),
    .rst            (rst),
    .mem_req_valid  (mem_req_valid),
    .mem_req_ready  (mem_req_ready),
    .mem_req_addr   (mem_req_addr),
    .mem_rsp_valid  (mem_rsp_valid),
    .mem_rsp_data   (mem_rsp_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .inst           (inst),
    .inst_pc        (inst_pc),
    .inst_valid     (inst_valid),
    .inst_ready     (inst_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    int          epoch;
    int          cyc;
  } req_t;

  req_t        memq[$];
  int          checks, failures, cyc, epoch, buffered;
  int          first_acc, first_val;
  logic [31:0] fetch_pc, exp_pc;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic bit roll(input int pct);
    return $urandom_range(99) < pct;
  endfunction

  // One clock of stimulus, output checking and model update.
  task automatic step(input bit do_rst, input int p_mrdy, input int p_rsp, input int p_irdy,
                      input int p_redir, input bit rand_tgt, input logic [31:0] tgt);
    bit          rsp_now, exp_req;
    req_t        e;
    logic [31:0] tgt_aligned;
    @(negedge clk);
    rst            = do_rst;
    mem_req_ready  = roll(p_mrdy);
    inst_ready     = roll(p_irdy);
    redirect_valid = !do_rst && roll(p_redir);
    redirect_pc    = rand_tgt ? $urandom : tgt;
    rsp_now        = !do_rst && memq.size() > 0 && memq[0].cyc < cyc && roll(p_rsp);
    mem_rsp_valid  = rsp_now;
    mem_rsp_data   = rsp_now ? (memq[0].addr ^ DATA_KEY) : $urandom;
    #1;
    if (do_rst) begin
      check("rst_req_valid", {31'd0, mem_req_valid}, 32'd0);
      check("rst_inst_valid", {31'd0, inst_valid}, 32'd0);
      check("rst_req_addr", mem_req_addr, 32'd0);
      check("rst_inst_pc", inst_pc, 32'd0);
      check("rst_inst", inst, 32'd0);
      memq.delete();
      buffered = 0;
      epoch++;
      fetch_pc = RESET_PC;
      exp_pc   = RESET_PC;
    end else begin
      exp_req = (memq.size() + buffered) < DEPTH;
      check("req_valid", {31'd0, mem_req_valid}, {31'd0, exp_req});
      if (exp_req) check("req_addr", mem_req_addr, fetch_pc);
`ifndef MR_IF_RSP_BYPASS_EN
      check("inst_valid", {31'd0, inst_valid}, {31'd0, buffered > 0});
`endif
      if (first_acc < 0 && mem_req_valid && mem_req_ready) first_acc = cyc;
      if (first_val < 0 && inst_valid) first_val = cyc;
      if (inst_valid && inst_ready) begin
        check("inst_pc", inst_pc, exp_pc);
        check("inst_data", inst, exp_pc ^ DATA_KEY);
        exp_pc += 32'd4;
        if (buffered > 0) buffered--;
      end
      if (mem_req_valid && mem_req_ready) begin
        memq.push_back('{addr: fetch_pc, epoch: epoch, cyc: cyc});
        fetch_pc += 32'd4;
      end
      if (rsp_now) begin
        e = memq.pop_front();
        if (e.epoch == epoch && !redirect_valid) buffered++;
      end
      if (redirect_valid) begin
        tgt_aligned = {redirect_pc[31:2], 2'b00};
        buffered = 0;
        epoch++;
        fetch_pc = tgt_aligned;
        exp_pc   = tgt_aligned;
      end
    end
    cyc++;
  endtask

  task automatic run(input int n, input int p_mrdy, input int p_rsp, input int p_irdy);
    for (int i = 0; i < n; i++) step(1'b0, p_mrdy, p_rsp, p_irdy, 0, 1'b0, 32'd0);
  endtask

  initial begin
    checks = 0; failures = 0; cyc = 0; epoch = 0; buffered = 0;
    fetch_pc = RESET_PC; exp_pc = RESET_PC;
    rst = 1'b1; mem_req_ready = 1'b0; mem_rsp_valid = 1'b0; mem_rsp_data = '0;
    redirect_valid = 1'b0; redirect_pc = '0; inst_ready = 1'b0;

    // Reset release into a single-cycle memory with decode always ready.
    for (int i = 0; i < 3; i++) step(1'b1, 100, 100, 100, 0, 1'b0, 32'd0);
    first_acc = -1; first_val = -1;
    run(12, 100, 100, 100);
    check("first_latency", first_val - first_acc, 32'd2);

    // Decode stalled: credit caps fetch at DEPTH, then drains in order.
    run(10, 100, 100, 0);
    run(8, 100, 100, 100);

    // Two requests in flight when a redirect lands.
    run(4, 100, 100, 100);
    run(2, 100, 0, 0);
    step(1'b0, 0, 0, 0, 100, 1'b0, 32'h0000_0100);
    run(10, 100, 100, 100);

    // Redirect coincident with an accept and a returning response.
    run(5, 100, 100, 100);
    step(1'b0, 100, 100, 100, 100, 1'b0, 32'h0000_0200);
    run(10, 100, 100, 100);

    // PC wrap through the top of the address space.
    step(1'b0, 100, 100, 100, 100, 1'b0, 32'hFFFF_FFFE);
    run(10, 100, 100, 100);

    // Reset mid-stream with requests outstanding.
    run(2, 100, 0, 0);
    step(1'b1, 100, 100, 100, 0, 1'b0, 32'd0);
    step(1'b1, 100, 100, 100, 0, 1'b0, 32'd0);
    run(12, 100, 100, 100);

    // Random traffic with occasional redirects to random targets.
    for (int i = 0; i < 3000; i++) begin
      step(1'b0, 70, 60, 65, 4, 1'b1, 32'd0);
    end
    run(20, 100, 100, 100);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
